id_ex_stage: RTL and testbench
==============================

Name:
id_ex_stage

Overview:
ID/EX pipeline register directly upstream of the 32-bit ALU. It captures decoded operands and control from ID and selects the ALU operands: register, immediate, or forwarded from EX/MEM and MEM/WB. It drives ctl/data_1/data_2 straight into the ALU and raises the load-use stall request toward ID.

Parameters:
FWD_EN, 1, 1 enables operand forwarding; 0 always uses the registered operand values.

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst_n  in  1  reset, synchronous and active-low
stall  in  1  downstream stall: hold stage contents
flush  in  1  squash: load a bubble
id_valid  in  1  ID holds a real instruction
id_alu_ctl  in  4  ALU op code, encodings from alu_ops.vh
id_rs  in  5  source register 1 number
id_rt  in  5  source register 2 number
id_rd  in  5  final destination register, already muxed by ID
id_rs_data  in  32  register file read port 1
id_rt_data  in  32  register file read port 2
id_imm  in  16  instruction immediate
id_alu_src  in  1  1 means data_2 is the immediate
id_imm_zext  in  1  1 zero-extends, 0 sign-extends id_imm
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  load
id_mem_write  in  1  store
exmem_rd  in  5  EX/MEM write destination; 0 means no write
exmem_result  in  32  EX/MEM ALU result
memwb_rd  in  5  MEM/WB write destination; 0 means no write
memwb_result  in  32  MEM/WB writeback value
load_use_stall  out  1  combinational; ID must hold and the stage inserts a bubble
ex_valid  out  1  stage holds a real instruction
ex_alu_ctl  out  4  to ALU ctl
ex_alu_data_1  out  32  to ALU data_1, forwarded rs
ex_alu_data_2  out  32  to ALU data_2, immediate or forwarded rt
ex_store_data  out  32  forwarded rt, for stores
ex_rd  out  5  destination register
ex_reg_write  out  1  gated by ex_valid
ex_mem_read  out  1  gated by ex_valid
ex_mem_write  out  1  gated by ex_valid

Behaviour:
- Reset, on a clk edge with rst_n=0: every register clears, so all outputs are 0 and ex_valid=0; load_use_stall=0 follows. Reset overrides stall and flush, including mid-stall.
- Edge priority: reset > flush > stall > load_use_stall > capture.
- Flush or load_use_stall loads a bubble: valid, ctl, rd, write/read flags and data registers all 0.
- Capture takes 1-cycle latency. At the edge the stage registers the ID fields and a 32-bit immediate: {16'b0,id_imm} when id_imm_zext=1, otherwise the sign-extended id_imm. The control flags are registered ANDed with id_valid.
- Forward function, combinational: fwd(r,q) = exmem_result when FWD_EN, r!=0 and exmem_rd==r; otherwise memwb_result when FWD_EN, r!=0 and memwb_rd==r; otherwise q. EX/MEM has priority over MEM/WB, and register 0 is never forwarded.
- Operand outputs: ex_alu_data_1 = fwd(rs,rs_q) and ex_store_data = fwd(rt,rt_q). ex_alu_data_2 = imm_q when alu_src_q=1, otherwise fwd(rt,rt_q).
- Stall: all control and the immediate hold. rs_q and rt_q reload with fwd(rs,rs_q) and fwd(rt,rt_q), so a forwarded value survives the producer leaving the pipe.
- load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (id_rs==ex_rd | (rt_used & id_rt==ex_rd)), with rt_used = ~id_alu_src | id_mem_write. It is combinational and asserts in the same cycle as the hazard.

Test Plan:
- Reset: hold stall=1 with a valid instruction in the stage, then assert rst_n=0 for one edge -> all outputs 0 and ex_valid=0.
- Capture: id_alu_ctl=`ADD, rs=1, rs_data=5, imm=0xFFFF, alu_src=1, zext=0 -> next cycle data_1=5, data_2=0xFFFFFFFF, ex_valid=1. Repeat with zext=1 -> data_2=0x0000FFFF.
- Forwarding, ex rs=3, rs_q=0x1:
  - exmem_rd=3 (0xA) and memwb_rd=3 (0xB) -> data_1=0xA.
  - exmem_rd=0 -> data_1=0xB.
  - rs=0 with both rd=0 -> data_1=rs_q.
  - FWD_EN=0 -> data_1=0x1.
- Load-use:
  - EX holds a load with rd=4 and ID has rs=4 -> load_use_stall=1 in the same cycle; after the next edge ex_valid=0 and ex_reg_write=0.
  - ID has rt=4 with alu_src=1 and mem_write=0 -> load_use_stall=0.
- Stall refresh: stall=1 for 2 cycles with ex rs=5; cycle 1 memwb_rd=5 with result 0x55, cycle 2 memwb_rd=0 -> data_1 stays 0x55 through cycle 2 and after stall releases.
- flush=1 and stall=1 on the same edge -> bubble, ex_valid=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 32-bit ALU: captures decoded fields, selects and forwards
// ALU operands, and raises the load-use stall request toward ID.
module id_ex_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [3:0]  id_alu_ctl,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [15:0] id_imm,
  input  logic        id_alu_src,
  input  logic        id_imm_zext,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic        load_use_stall,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_ctl,
  output logic [31:0] ex_alu_data_1,
  output logic [31:0] ex_alu_data_2,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write
);

  logic        valid_r;
  logic [3:0]  alu_ctl_r;
  logic [4:0]  rs_r;
  logic [4:0]  rt_r;
  logic [4:0]  rd_r;
  logic [31:0] rs_q_r;
  logic [31:0] rt_q_r;
  logic [31:0] imm_r;
  logic        alu_src_r;
  logic        reg_write_r;
  logic        mem_read_r;
  logic        mem_write_r;

  logic [31:0] fwd_rs_s;
  logic [31:0] fwd_rt_s;
  logic        rt_used_s;
  logic        load_use_s;
  logic        bubble_s;

  // EX/MEM beats MEM/WB; register 0 is hardwired and never forwarded.
  function automatic logic [31:0] fwd(
    input logic [4:0]  r,
    input logic [31:0] q,
    input logic [4:0]  xm_rd,
    input logic [31:0] xm_val,
    input logic [4:0]  mw_rd,
    input logic [31:0] mw_val
  );
    logic [31:0] res;
    if (FWD_EN && (r != 5'd0) && (xm_rd == r)) begin
      res = xm_val;
    end else if (FWD_EN && (r != 5'd0) && (mw_rd == r)) begin
      res = mw_val;
    end else begin
      res = q;
    end
    return res;
  endfunction

  function automatic logic [31:0] imm_ext(input logic [15:0] imm, input logic zext);
    logic [31:0] res;
    if (zext) begin
      res = {16'h0000, imm};
    end else begin
      res = {{16{imm[15]}}, imm};
    end
    return res;
  endfunction

  assign fwd_rs_s = fwd(rs_r, rs_q_r, exmem_rd, exmem_result, memwb_rd, memwb_result);
  assign fwd_rt_s = fwd(rt_r, rt_q_r, exmem_rd, exmem_result, memwb_rd, memwb_result);

  // Load-use hazard: rt only matters when it feeds the ALU or is store data.
  always_comb begin
    rt_used_s  = ~id_alu_src | id_mem_write;
    load_use_s = valid_r & mem_read_r & (rd_r != 5'd0) & id_valid &
                 ((id_rs == rd_r) | (rt_used_s & (id_rt == rd_r)));
  end

  assign bubble_s = ~rst_n | flush | (~stall & load_use_s);

  // Stage register: bubble, stall with operand refresh, or capture from ID.
  always_ff @(posedge clk) begin
    if (bubble_s) begin
      valid_r     <= 1'b0;
      alu_ctl_r   <= 4'd0;
      rs_r        <= 5'd0;
      rt_r        <= 5'd0;
      rd_r        <= 5'd0;
      rs_q_r      <= 32'd0;
      rt_q_r      <= 32'd0;
      imm_r       <= 32'd0;
      alu_src_r   <= 1'b0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else if (stall) begin
      // Latch forwarded operands so they outlive the producer leaving the pipe.
      rs_q_r <= fwd_rs_s;
      rt_q_r <= fwd_rt_s;
    end else begin
      valid_r     <= id_valid;
      alu_ctl_r   <= id_alu_ctl;
      rs_r        <= id_rs;
      rt_r        <= id_rt;
      rd_r        <= id_rd;
      rs_q_r      <= id_rs_data;
      rt_q_r      <= id_rt_data;
      imm_r       <= imm_ext(id_imm, id_imm_zext);
      alu_src_r   <= id_alu_src;
      reg_write_r <= id_reg_write & id_valid;
      mem_read_r  <= id_mem_read & id_valid;
      mem_write_r <= id_mem_write & id_valid;
    end
  end

  assign load_use_stall = load_use_s;
  assign ex_valid       = valid_r;
  assign ex_alu_ctl     = alu_ctl_r;
  assign ex_alu_data_1  = fwd_rs_s;
  assign ex_alu_data_2  = alu_src_r ? imm_r : fwd_rt_s;
  assign ex_store_data  = fwd_rt_s;
  assign ex_rd          = rd_r;
  assign ex_reg_write   = valid_r & reg_write_r;
  assign ex_mem_read    = valid_r & mem_read_r;
  assign ex_mem_write   = valid_r & mem_write_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expectations are queued as stimulus is driven and
// drained against a forwarding instance and a non-forwarding instance.
module tb_id_ex_stage;

  localparam logic [3:0] ALU_ADD = 4'h2;

  localparam int S_VALID = 0, S_CTL = 1, S_D1 = 2, S_D2 = 3, S_ST = 4, S_RD = 5,
                 S_RW = 6, S_MR = 7, S_MW = 8, S_LUS = 9, S_NF_D1 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, flush, id_valid;
  logic [3:0]  id_alu_ctl;
  logic [4:0]  id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
  logic [31:0] id_rs_data, id_rt_data, exmem_result, memwb_result;
  logic [15:0] id_imm;
  logic        id_alu_src, id_imm_zext, id_reg_write, id_mem_read, id_mem_write;

  logic        load_use_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [3:0]  ex_alu_ctl;
  logic [31:0] ex_alu_data_1, ex_alu_data_2, ex_store_data;
  logic [4:0]  ex_rd;

  logic        nf_lus, nf_valid, nf_rw, nf_mr, nf_mw;
  logic [3:0]  nf_ctl;
  logic [31:0] nf_d1, nf_d2, nf_st;
  logic [4:0]  nf_rd;

  id_ex_stage #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_ctl(id_alu_ctl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_imm_zext(id_imm_zext), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_alu_ctl(ex_alu_ctl),
    .ex_alu_data_1(ex_alu_data_1), .ex_alu_data_2(ex_alu_data_2),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  id_ex_stage #(.FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_ctl(id_alu_ctl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_imm_zext(id_imm_zext), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .load_use_stall(nf_lus), .ex_valid(nf_valid), .ex_alu_ctl(nf_ctl),
    .ex_alu_data_1(nf_d1), .ex_alu_data_2(nf_d2),
    .ex_store_data(nf_st), .ex_rd(nf_rd), .ex_reg_write(nf_rw),
    .ex_mem_read(nf_mr), .ex_mem_write(nf_mw)
  );

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_VALID: observe = {31'd0, ex_valid};
      S_CTL:   observe = {28'd0, ex_alu_ctl};
      S_D1:    observe = ex_alu_data_1;
      S_D2:    observe = ex_alu_data_2;
      S_ST:    observe = ex_store_data;
      S_RD:    observe = {27'd0, ex_rd};
      S_RW:    observe = {31'd0, ex_reg_write};
      S_MR:    observe = {31'd0, ex_mem_read};
      S_MW:    observe = {31'd0, ex_mem_write};
      S_LUS:   observe = {31'd0, load_use_stall};
      S_NF_D1: observe = nf_d1;
      default: observe = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [15:0] imm, input logic src, input logic zx,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_alu_ctl = ALU_ADD;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_alu_src = src; id_imm_zext = zx;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic push_zero_state(input string pfx);
    push({pfx, "_valid"}, S_VALID, 32'd0);
    push({pfx, "_ctl"},   S_CTL,   32'd0);
    push({pfx, "_d1"},    S_D1,    32'd0);
    push({pfx, "_d2"},    S_D2,    32'd0);
    push({pfx, "_st"},    S_ST,    32'd0);
    push({pfx, "_rd"},    S_RD,    32'd0);
    push({pfx, "_rw"},    S_RW,    32'd0);
    push({pfx, "_mr"},    S_MR,    32'd0);
    push({pfx, "_mw"},    S_MW,    32'd0);
    push({pfx, "_lus"},   S_LUS,   32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    exmem_rd = 5'd0; exmem_result = 32'd0; memwb_rd = 5'd0; memwb_result = 32'd0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    push_zero_state("init");
    drain();

    // Capture with sign- and zero-extended immediates.
    set_id(1'b1, 5'd1, 5'd2, 5'd6, 32'd5, 32'd7, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    push("cap_valid", S_VALID, 32'd1);
    push("cap_ctl",   S_CTL,   {28'd0, ALU_ADD});
    push("cap_d1",    S_D1,    32'd5);
    push("cap_d2_sx", S_D2,    32'hFFFF_FFFF);
    push("cap_st",    S_ST,    32'd7);
    push("cap_rd",    S_RD,    32'd6);
    push("cap_rw",    S_RW,    32'd1);
    drain();
    id_imm_zext = 1'b1;
    tick();
    push("cap_d2_zx", S_D2, 32'h0000_FFFF);
    drain();
    id_imm_zext = 1'b0; id_imm = 16'h1234;
    tick();
    push("cap_d2_pos", S_D2, 32'h0000_1234);
    drain();

    // Forwarding priority on rs=3 with rs_q=1.
    set_id(1'b1, 5'd3, 5'd0, 5'd9, 32'h1, 32'h77, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_valid = 1'b0;
    exmem_rd = 5'd3; exmem_result = 32'hA; memwb_rd = 5'd3; memwb_result = 32'hB;
    push("fwd_exmem",   S_D1,    32'hA);
    push("fwd_nf",      S_NF_D1, 32'h1);
    push("fwd_rt0_st",  S_ST,    32'h77);
    drain();
    exmem_rd = 5'd0;
    push("fwd_memwb",   S_D1,    32'hB);
    drain();

    // Register 0 never forwards, even with rd=0 matching.
    memwb_rd = 5'd0;
    set_id(1'b1, 5'd0, 5'd7, 5'd9, 32'h99, 32'h70, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    push("fwd_r0", S_D1, 32'h99);
    push("rt_nofwd_d2", S_D2, 32'h70);
    drain();
    memwb_rd = 5'd7; memwb_result = 32'hB;
    push("fwd_rt_d2", S_D2, 32'hB);
    push("fwd_rt_st", S_ST, 32'hB);
    drain();
    memwb_rd = 5'd0; memwb_result = 32'd0; exmem_result = 32'd0;

    // Load-use on rs: same-cycle request, bubble after the edge.
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd4, 5'd0, 5'd8, 32'h3, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push("lu_mr",  S_MR,  32'd1);
    push("lu_rs",  S_LUS, 32'd1);
    drain();
    tick();
    push("lu_bub_valid", S_VALID, 32'd0);
    push("lu_bub_rw",    S_RW,    32'd0);
    push("lu_bub_lus",   S_LUS,   32'd0);
    drain();

    // rt hazard depends on whether rt is actually used.
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd4, 5'd8, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    push("lu_rt_imm", S_LUS, 32'd0);
    drain();
    id_mem_write = 1'b1;
    push("lu_rt_store", S_LUS, 32'd1);
    drain();
    id_mem_write = 1'b0; id_alu_src = 1'b0;
    push("lu_rt_reg", S_LUS, 32'd1);
    drain();
    id_valid = 1'b0;
    push("lu_id_inv", S_LUS, 32'd0);
    drain();

    // Stall refresh keeps a forwarded value after the producer leaves.
    set_id(1'b1, 5'd5, 5'd0, 5'd10, 32'h5, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_valid = 1'b0; stall = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h55;
    push("stl_c1",    S_D1,    32'h55);
    push("stl_c1_nf", S_NF_D1, 32'h5);
    drain();
    tick();
    memwb_rd = 5'd0; memwb_result = 32'd0;
    push("stl_c2",       S_D1,    32'h55);
    push("stl_c2_valid", S_VALID, 32'd1);
    push("stl_c2_nf",    S_NF_D1, 32'h5);
    drain();
    tick();
    stall = 1'b0;
    push("stl_rel",    S_D1, 32'h55);
    push("stl_rel_rd", S_RD, 32'd10);
    drain();

    // Flush wins over stall.
    set_id(1'b1, 5'd2, 5'd3, 5'd11, 32'h22, 32'h33, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    push("pre_flush_valid", S_VALID, 32'd1);
    drain();
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    push("flush_valid", S_VALID, 32'd0);
    push("flush_d1",    S_D1,    32'd0);
    push("flush_rd",    S_RD,    32'd0);
    drain();

    // Reset overrides an ongoing stall.
    set_id(1'b1, 5'd1, 5'd2, 5'd6, 32'd5, 32'd7, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    push("pre_rst_valid", S_VALID, 32'd1);
    push("pre_rst_d2",    S_D2,    32'hFFFF_8000);
    push("pre_rst_mw",    S_MW,    32'd1);
    drain();
    stall = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push_zero_state("rst");
    drain();
    stall = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
